// File: rtl/mul16_seq.sv
// Sequential 16x16 -> 32-bit unsigned shift-add multiplier with ready/valid handshakes.
// Optional macro MUL16_EARLY_TERM_EN: leave RUN as soon as no multiplier bits remain.

module Add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {32'b0, cin};
  assign sum  = full[31:0];
  assign cout = full[32];

endmodule

module mul16_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;

  generate
    if (WIDTH != 16) begin : g_bad_width
      $error("mul16_seq: WIDTH must be 16 (product feeds a fixed 32-bit Add32)");
    end
    if (WIDTH >= (1 << CNT_W)) begin : g_bad_cnt
      $error("mul16_seq: CNT_W too narrow to count WIDTH iterations");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     p;
  logic [PW-1:0]     m;
  logic [WIDTH-1:0]  q;
  logic [CNT_W-1:0]  cnt;
  logic [PW-1:0]     addend;
  logic [PW-1:0]     sum;
  logic              add_cout;
  logic              last_iter;

  assign addend = q[0] ? m : '0;

  Add32 u_add (
    .a    (p),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (add_cout)
  );

`ifdef MUL16_EARLY_TERM_EN
  // q[WIDTH-1:1] is what remains of the multiplier after this iteration's shift
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (q[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      p         <= '0;
      m         <= '0;
      q         <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m     <= PW'(a);
            q     <= b;
            p     <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          p   <= sum;
          m   <= m << 1;
          q   <= q >> 1;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            state     <= DONE;
            out_valid <= 1'b1;
            product   <= sum;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The product always fits in PW bits, so the shared adder never carries out.
  a_no_carry: assert property (@(posedge clk) disable iff (!rst_n)
                               (state == RUN) |-> !add_cout);

endmodule

// File: tb/tb_mul16_seq.sv
// Directed, table-driven bench for mul16_seq: results, latency, backpressure, mid-run reset.

module tb_mul16_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int n_cmp;
  int n_miss;
  int carry_hits;

  mul16_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RUN is busy with out_valid still low; the shared adder must never carry there.
  always @(negedge clk)
    if (rst_n && busy && !out_valid && dut.add_cout) carry_hits++;

`ifdef MUL16_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    int          hold;
    logic [31:0] exp_p;
    int          lat_full;
    int          lat_et;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called one step after a rising edge with the DUT idle.
  task automatic run_vec(input logic [15:0] va, input logic [15:0] vb, input int hold,
                         input logic [31:0] exp_p, input int exp_lat);
    int lat;
    a         = va;
    b         = vb;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~va;
    b        = ~vb;
    chk("busy_after_accept", {30'b0, in_ready, busy}, 32'h1);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    chk("latency", lat, exp_lat);
    chk("product", product, exp_p);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid_ready", {30'b0, out_valid, in_ready}, 32'h2);
      chk("hold_product", product, exp_p);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_state", {29'b0, out_valid, busy, in_ready}, 32'h1);
  endtask

  vec_t vecs[9];

  initial begin
    n_cmp      = 0;
    n_miss     = 0;
    carry_hits = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;

    vecs[0] = '{16'h0003, 16'h0005, 0,  32'h0000000F, 16, 3};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 0,  32'hFFFE0001, 16, 16};
    vecs[2] = '{16'h1234, 16'h0100, 10, 32'h00123400, 16, 9};
    vecs[3] = '{16'h0002, 16'h0003, 0,  32'h00000006, 16, 2};
    vecs[4] = '{16'h00AB, 16'h0000, 0,  32'h00000000, 16, 1};
    vecs[5] = '{16'h00AB, 16'h0001, 0,  32'h000000AB, 16, 1};
    vecs[6] = '{16'h00AB, 16'h8000, 0,  32'h00558000, 16, 16};
    vecs[7] = '{16'h8000, 16'h8000, 3,  32'h40000000, 16, 16};
    vecs[8] = '{16'h0000, 16'hFFFF, 0,  32'h00000000, 16, 16};

    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_flags", {29'b0, in_ready, out_valid, busy}, 32'h4);
    chk("reset_product", product, 32'h0);

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i].va, vecs[i].vb, vecs[i].hold, vecs[i].exp_p,
              ET ? vecs[i].lat_et : vecs[i].lat_full);

    // Abort a run at cnt=7 and confirm nothing stale survives.
    a        = 16'h00FF;
    b        = 16'h00FF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_flags", {29'b0, in_ready, out_valid, busy}, 32'h4);
    chk("midreset_product", product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_idle", {29'b0, in_ready, out_valid, busy}, 32'h4);
    run_vec(16'h0007, 16'h0006, 0, 32'h0000002A, ET ? 3 : 16);

    chk("adder_carry_hits", carry_hits, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Sequential 16x16 -> 32-bit unsigned shift-add multiplier controller.
- One instance of the existing 32-bit adder `Add32` is time-shared over iterations; this block owns the FSM, operand registers, iteration counter and handshake.
- Sits beside the ALU as the multi-cycle MUL unit. Ready/valid on both sides.

Parameters:
- WIDTH, 16, operand width. Only 16 is legal because the product is 2*WIDTH = 32 and `Add32` is fixed width. Elaboration error for any other value.
- CNT_W, 5, iteration counter width. Must hold WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands (1 only in IDLE)
- a  in  16  multiplicand
- b  in  16  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  32  result, held stable while out_valid=1
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, P=0, M=0, Q=0, cnt=0.
  - Outputs: out_valid=0, product=0, busy=0, in_ready=1 (combinational from IDLE).
  - Reset mid-operation aborts immediately; the partial product is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at the edge: M<={16'b0,a}, Q<=b, P<=0, cnt<=0, go to RUN.
  - a and b are sampled only at this edge.
- RUN (one iteration per clock):
  - `Add32` computes P + (Q[0] ? M : 0), carry-in 0.
  - P<=sum; M<=M<<1; Q<=Q>>1; cnt<=cnt+1.
  - When cnt==15, go to DONE with the final P.
  - Adder carry-out is ignored. It must be 0 because the product fits in 32 bits; verification asserts carry==0 every RUN cycle.
- DONE:
  - out_valid=1 and product=P.
  - On out_ready=1 at the edge, go to IDLE. out_valid drops next cycle.
  - No new operands are accepted in DONE (in_ready=0).
  - Back-to-back throughput is one result per 18 cycles with out_ready held 1.
- Latency (macro undefined):
  - Input handshake at edge N.
  - 16 RUN cycles.
  - out_valid=1 from edge N+16 to the out_ready edge.
- Holding rules:
  - While out_valid=1 and out_ready=0, product and out_valid hold indefinitely.
  - product keeps its last value in IDLE; it is only defined while out_valid=1.
- Simultaneous events:
  - in_valid outside IDLE is ignored and no request is queued.
  - out_ready outside DONE is ignored.
- busy=1 in RUN and DONE.

Optional Feature:
- Macro: MUL16_EARLY_TERM_EN.
- Defined:
  - RUN also exits to DONE after any iteration where (Q>>1)==0, i.e. no remaining multiplier bits.
  - RUN cycle count = max(1, index of the most significant set bit of b + 1). b=0 takes 1 cycle; b=0x8000 takes 16 cycles.
  - Results are identical to the macro-undefined build.
- Undefined: always exactly 16 RUN cycles regardless of b.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n=0, release.
  - Required: in_ready=1, out_valid=0, busy=0, product=0.
- Basic multiply:
  - Stimulus: a=0x0003, b=0x0005, out_ready=1.
  - Required: product=0x0000000F. out_valid rises exactly 16 cycles after the input handshake (macro off), and is high for 1 cycle.
- Max operands:
  - Stimulus: a=0xFFFF, b=0xFFFF.
  - Required: product=0xFFFE0001; adder carry-out never 1.
- Backpressure:
  - Stimulus: a=0x1234, b=0x0100, out_ready=0 for 10 cycles, then 1.
  - Required: product=0x00123400 stable and out_valid=1 throughout; in_ready=0 until the cycle after the out_ready edge. A second request with a=2, b=3 then gives 6.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 at RUN cnt=7 for a=0x00FF, b=0x00FF.
  - Required: immediate IDLE, out_valid=0, busy=0. A new request with a=7, b=6 gives 42 with no stale data.
- Early termination (MUL16_EARLY_TERM_EN defined):
  - Stimulus: b=0x0000, then b=0x0001, then b=0x8000, each with a=0x00AB.
  - Required: results 0x0, 0xAB, 0x00558000.
  - Required: out_valid appears 1, 1 and 16 cycles after the respective handshakes.
